// File: rtl/ram_loader.sv
// ram_loader: boot loader that streams bytes into a 256x8 RAM, then reads the
// same region back and compares additive checksums.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        begin a transfer (IDLE only) / cancel any transfer
//   base_addr, length   first RAM address and byte count (1..2**ADDR_W),
//                       sampled on an accepted start
//   in_valid, in_data   byte stream in; in_ready high while loading
//   mem_read, mem_write RAM strobes (never both high)
//   mem_address         RAM address, (base + cnt) mod 2**ADDR_W
//   mem_data            RAM write data
//   mem_q               RAM combinational read data
//   busy                state is not IDLE
//   done                one-cycle completion pulse
//   pass, checksum      readback-matches flag and write checksum (registered)
module ram_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wsum;
  logic [DATA_W-1:0] rsum;
  logic              len_ok;
  logic              last;
  logic [ADDR_W-1:0] addr;

  assign len_ok = (length != '0) && (length <= DEPTH);
  assign last   = (cnt == (len - ONE));
  // Truncating add gives the modulo-depth wrap of the address.
  assign addr   = base + cnt[ADDR_W-1:0];
  assign busy   = (state != S_IDLE);

  always_comb begin
    in_ready    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    case (state)
      S_LOAD: begin
        in_ready    = 1'b1;
        mem_write   = in_valid;
        mem_address = addr;
        mem_data    = in_data;
      end
      S_VERIFY: begin
        mem_read    = 1'b1;
        mem_address = addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      len      <= '0;
      base     <= '0;
      wsum     <= '0;
      rsum     <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      checksum <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort && len_ok) begin
            base     <= base_addr;
            len      <= length;
            cnt      <= '0;
            wsum     <= '0;
            rsum     <= '0;
            pass     <= 1'b0;
            checksum <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (in_valid) begin
            wsum <= wsum + in_data;
            if (last) begin
              cnt   <= '0;
              state <= S_VERIFY;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        S_VERIFY: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            rsum <= rsum + mem_q;
            cnt  <= cnt + ONE;
            if (last) state <= S_DONE;
          end
        end
        S_DONE: begin
          // Results are published on the exit edge so done lands len+1
          // cycles after the last accepted byte.
          state <= S_IDLE;
          if (!abort) begin
            done     <= 1'b1;
            pass     <= (rsum == wsum);
            checksum <= wsum;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
